ir_queue: RTL and testbench
===========================

Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH fetched instruction words from the MBR in a circular queue.
- Presents the head entry split into opcode (to the CU) and operand (back to the MBR), each gated by its control-signal enable.
- Adds a load handshake, consume (pop), pipeline flush for taken branches, and a sticky underflow flag.

Parameters:
- INSTR_W, 16: instruction word width.
- OPC_W, 8: opcode field width, taken from the MSBs. Operand width is INSTR_W-OPC_W. Requires 1 <= OPC_W < INSTR_W.
- DEPTH, 4: number of queue entries. Power of two, >= 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_load_valid  in  1  MBR offers a word (C4 role).
- o_load_ready  out  1  queue can accept a word.
- i_instr  in  INSTR_W  instruction word from MBR.
- i_pop  in  1  CU has consumed the head entry.
- i_flush  in  1  discard all entries (taken branch / interrupt).
- i_opc_en  in  1  drive opcode to CU (C14 role).
- i_opr_en  in  1  drive operand to MBR (C15 role).
- o_opcode  out  OPC_W  head opcode when gated on, else 0.
- o_operand  out  INSTR_W-OPC_W  head operand when gated on, else 0.
- o_valid  out  1  queue non-empty.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- o_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (i_rst=1 at an edge), all outputs read as follows after that edge:
  - pointers=0, count=0, o_underflow=0
  - o_valid=0, o_load_ready=1
  - o_opcode=0, o_operand=0
  - Entry storage need not be cleared.
- Reset has priority over every other input, including mid-operation loads and pops.
- Storage: DEPTH x INSTR_W register array, write pointer wp, read pointer rp, occupancy counter cnt.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Handshake and ready:
  - o_load_ready = (cnt != DEPTH), combinational from registered state. No same-cycle pop bypass.
  - Push = i_load_valid && o_load_ready: mem[wp] <= i_instr, wp increments.
  - Load while full is ignored: no write, no error.
- Pop:
  - Pop = i_pop && o_valid: rp increments.
  - i_pop while empty: no state change except o_underflow <= 1.
  - o_underflow stays set until reset; flush does not clear it.
- Simultaneous push and pop: both take effect and cnt is unchanged.
  - Valid when non-full and non-empty.
  - When full, only the pop occurs; when empty, only the push occurs.
- Flush:
  - i_flush=1 sets wp, rp and cnt to 0.
  - Any push or pop in the same cycle is discarded.
  - An underflow event in the same cycle is still recorded.
- Latency:
  - A word accepted at edge N is visible on o_opcode/o_operand immediately after edge N, if it is the head.
  - A pop at edge N exposes the next entry after edge N.
- Output gating (combinational):
  - o_opcode = (i_opc_en && o_valid) ? mem[rp][INSTR_W-1:INSTR_W-OPC_W] : 0
  - o_operand = (i_opr_en && o_valid) ? mem[rp][INSTR_W-OPC_W-1:0] : 0
  - When empty, outputs are 0 regardless of the enables.
- o_valid = (cnt != 0). o_count = cnt.

Decomposition:
- Shared package ir_pkg holds:
  - defaults IR_INSTR_W=16, IR_OPC_W=8, IR_DEPTH=4
  - the opcode/operand field-split offsets
  - the occupancy-width calculation, also reused by the CU.
- No sub-module; pointer, counter and gating logic stay in ir_queue.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles, then 0 -> o_valid=0, o_load_ready=1, o_count=0, o_opcode=0, o_operand=0, o_underflow=0.
- Fill and drain, defaults: push 0x1A2B, 0x3C4D, 0x5E6F, 0x7081 -> o_count=4, o_load_ready=0.
  - A 5th push of 0xFFFF is ignored.
  - With i_opc_en=i_opr_en=1, four pops yield opcode/operand 1A/2B, 3C/4D, 5E/6F, 70/81 in order, then o_valid=0.
- Gating: queue holds 0xA55A.
  - i_opc_en=1, i_opr_en=0 -> o_opcode=0xA5, o_operand=0.
  - Swap the enables -> o_opcode=0, o_operand=0x5A.
- Simultaneous push/pop at cnt=2 -> cnt stays 2; order preserved.
  - Pointer wrap: run 10 push/pop pairs, check FIFO order across the DEPTH boundary.
- Flush: cnt=3 with i_flush=1, i_load_valid=1 (0x1234), i_pop=1 in the same cycle -> next cycle o_count=0, o_valid=0.
  - 0x1234 is not stored; the next push becomes the head.
- Underflow and reset priority:
  - Pop on empty -> o_underflow=1, persists through a flush.
  - i_rst=1 together with push -> o_count=0, o_underflow=0.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared instruction-register definitions: default geometry, field-split offsets
// and the occupancy-counter width used by the queue and the control unit.
package ir_pkg;

  localparam int IR_INSTR_W = 16;
  localparam int IR_OPC_W   = 8;
  localparam int IR_DEPTH   = 4;

  // The opcode occupies the MSBs, so the operand width equals the opcode LSB index.
  function automatic int ir_opr_w(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int ir_opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int ir_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_queue.sv
// Circular instruction queue fed by the MBR; the head word is split into a gated
// opcode (to the CU) and a gated operand (back to the MBR).
module ir_queue
  import ir_pkg::*;
#(
  parameter int INSTR_W = IR_INSTR_W,
  parameter int OPC_W   = IR_OPC_W,
  parameter int DEPTH   = IR_DEPTH,
  localparam int OPR_W  = ir_opr_w(INSTR_W, OPC_W),
  localparam int CNT_W  = ir_cnt_w(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_valid,
  output logic               o_load_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic               i_opc_en,
  input  logic               i_opr_en,
  output logic [OPC_W-1:0]   o_opcode,
  output logic [OPR_W-1:0]   o_operand,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_underflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OPC_LSB = ir_opc_lsb(INSTR_W, OPC_W);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               underflow_q, underflow_d;
  logic               push_s, pop_s, mem_we_s;
  logic [INSTR_W-1:0] head_s;

  assign o_load_ready = (cnt_q != CNT_W'(DEPTH));
  assign o_valid      = (cnt_q != {CNT_W{1'b0}});
  assign o_count      = cnt_q;
  assign o_underflow  = underflow_q;
  assign head_s       = mem_q[rp_q];

  // Flush wins over push/pop but an empty-pop still latches the sticky underflow.
  always_comb begin
    push_s      = i_load_valid && o_load_ready;
    pop_s       = i_pop && o_valid;
    mem_we_s    = push_s && !i_flush;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q | (i_pop & ~o_valid);
    if (i_flush) begin
      wp_d  = {PTR_W{1'b0}};
      rp_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wp_d = wp_q + PTR_W'(1);
      end else begin
        wp_d = wp_q;
      end
      if (pop_s) begin
        rp_d = rp_q + PTR_W'(1);
      end else begin
        rp_d = rp_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    if (i_opc_en && o_valid) begin
      o_opcode = head_s[INSTR_W-1:OPC_LSB];
    end else begin
      o_opcode = {OPC_W{1'b0}};
    end
    if (i_opr_en && o_valid) begin
      o_operand = head_s[OPR_W-1:0];
    end else begin
      o_operand = {OPR_W{1'b0}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q        <= {PTR_W{1'b0}};
      rp_q        <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage is deliberately left uncleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we_s) begin
      mem_q[wp_q] <= i_instr;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue with default geometry (16-bit words, 8-bit opcode, depth 4).
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst, lv, pop, flush, opc_en, opr_en;
  logic        load_ready, valid, underflow;
  logic [15:0] instr;
  logic [7:0]  opcode, operand;
  logic [2:0]  count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_w;

  ir_queue dut (
    .i_clk(clk), .i_rst(rst), .i_load_valid(lv), .o_load_ready(load_ready),
    .i_instr(instr), .i_pop(pop), .i_flush(flush), .i_opc_en(opc_en),
    .i_opr_en(opr_en), .o_opcode(opcode), .o_operand(operand), .o_valid(valid),
    .o_count(count), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [15:0] w);
    lv = 1'b1; instr = w;
    tick();
    lv = 1'b0;
  endtask

  task automatic drive_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lv = 1'b0; pop = 1'b0; flush = 1'b0; instr = 16'h0000;
    opc_en = 1'b1; opr_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL reset_opcode got=%h exp=00", opcode); end
    checks++; if (operand !== 8'h00) begin failures++; $display("FAIL reset_operand got=%h exp=00", operand); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_fill_drain();
    logic [15:0] words [4] = '{16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081};
    for (int i = 0; i < 4; i++) begin
      drive_push(words[i]);
      sb.push_back(words[i]);
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", load_ready); end
    drive_push(16'hFFFF);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_push_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      exp_w = sb.pop_front();
      checks++; if (opcode !== exp_w[15:8]) begin failures++; $display("FAIL drain_opcode[%0d] got=%h exp=%h", i, opcode, exp_w[15:8]); end
      checks++; if (operand !== exp_w[7:0]) begin failures++; $display("FAIL drain_operand[%0d] got=%h exp=%h", i, operand, exp_w[7:0]); end
      drive_pop();
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", valid); end
    checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL drain_empty_opcode got=%h exp=00", opcode); end
  endtask

  task automatic test_gating();
    drive_push(16'hA55A);
    sb.push_back(16'hA55A);
    opc_en = 1'b1; opr_en = 1'b0; #1;
    checks++; if (opcode !== 8'hA5) begin failures++; $display("FAIL gate_opc_on got=%h exp=a5", opcode); end
    checks++; if (operand !== 8'h00) begin failures++; $display("FAIL gate_opr_off got=%h exp=00", operand); end
    opc_en = 1'b0; opr_en = 1'b1; #1;
    checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL gate_opc_off got=%h exp=00", opcode); end
    checks++; if (operand !== 8'h5A) begin failures++; $display("FAIL gate_opr_on got=%h exp=5a", operand); end
    opc_en = 1'b1;
    void'(sb.pop_front());
    drive_pop();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL gate_empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    drive_push(16'h0F01); sb.push_back(16'h0F01);
    drive_push(16'h0F02); sb.push_back(16'h0F02);
    for (int i = 0; i < 10; i++) begin
      exp_w = sb[0];
      checks++; if ({opcode, operand} !== exp_w) begin failures++; $display("FAIL b2b_head[%0d] got=%h exp=%h", i, {opcode, operand}, exp_w); end
      lv = 1'b1; pop = 1'b1; instr = 16'h1000 + 16'(i);
      tick();
      lv = 1'b0; pop = 1'b0;
      void'(sb.pop_front());
      sb.push_back(16'h1000 + 16'(i));
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
    end
    while (sb.size() != 0) begin
      exp_w = sb.pop_front();
      checks++; if ({opcode, operand} !== exp_w) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", {opcode, operand}, exp_w); end
      drive_pop();
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", valid); end
  endtask

  task automatic test_flush();
    drive_push(16'h1111); drive_push(16'h2222); drive_push(16'h3333);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush = 1'b1; lv = 1'b1; pop = 1'b1; instr = 16'h1234;
    tick();
    flush = 1'b0; lv = 1'b0; pop = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL flush_underflow got=%b exp=0", underflow); end
    drive_push(16'hBEEF); sb.push_back(16'hBEEF);
    exp_w = sb.pop_front();
    checks++; if ({opcode, operand} !== exp_w) begin failures++; $display("FAIL flush_head got=%h exp=%h", {opcode, operand}, exp_w); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL flush_head_count got=%0d exp=1", count); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_underflow_reset();
    drive_pop();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", underflow); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL uf_count got=%0d exp=0", count); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_after_flush got=%b exp=1", underflow); end
    drive_push(16'h4242);
    rst = 1'b1; lv = 1'b1; instr = 16'h5555;
    tick();
    rst = 1'b0; lv = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_prio_count got=%0d exp=0", count); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL rst_prio_underflow got=%b exp=0", underflow); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_prio_valid got=%b exp=0", valid); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_prio_ready got=%b exp=1", load_ready); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_gating();
    test_back_to_back();
    test_flush();
    test_underflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
